// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-stage PC generator.
package pc_gen_pkg;

   // next-PC source select
   localparam logic [1:0] PC_SRC_BOOT = 2'd0;
   localparam logic [1:0] PC_SRC_EPC  = 2'd1;
   localparam logic [1:0] PC_SRC_TRAP = 2'd2;
   localparam logic [1:0] PC_SRC_NEXT = 2'd3;

   // controller states
   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // class of a buffered redirect; higher value wins
   localparam logic [1:0] PRIO_NONE   = 2'd0;
   localparam logic [1:0] PRIO_BRANCH = 2'd1;
   localparam logic [1:0] PRIO_RET    = 2'd2;
   localparam logic [1:0] PRIO_TRAP   = 2'd3;

   // map a source select onto its redirect class
   function automatic logic [1:0] src_prio(input logic [1:0] src);
      logic [1:0] p;
      case (src)
         PC_SRC_TRAP: p = PRIO_TRAP;
         PC_SRC_NEXT: p = PRIO_BRANCH;
         default:     p = PRIO_RET;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/pc_gen_unit_target_sel.sv
// Combinational next-PC mux, step adder and redirect/misalignment decode.
module pc_target_sel
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter logic [XLEN-1:0] BOOT_ADDR = '0,
   parameter int unsigned C_EXT     = 0
) (
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] epc,
   input  logic [XLEN-1:0] trap_address,
   input  logic            branch_taken,
   input  logic [XLEN-2:0] iaddr,
   input  logic            instr_len2,
   output logic [XLEN-1:0] pc_plus_inc_c,
   output logic [XLEN-1:0] target_c,
   output logic            redirect_c,
   output logic            misaligned_c,
   output logic [1:0]      prio_c
);

   localparam logic [XLEN-1:0] STEP2 = XLEN'(2);
   localparam logic [XLEN-1:0] STEP4 = XLEN'(4);

   // sequential step, target select and redirect classification
   always_comb begin
      pc_plus_inc_c = pc + (((C_EXT != 0) && instr_len2) ? STEP2 : STEP4);
      redirect_c    = (pc_src != PC_SRC_NEXT) || branch_taken;
      prio_c        = src_prio(pc_src);
      case (pc_src)
         PC_SRC_BOOT: target_c = BOOT_ADDR;
         PC_SRC_EPC:  target_c = epc;
         PC_SRC_TRAP: target_c = trap_address;
         default:     target_c = branch_taken ? {iaddr, 1'b0} : pc_plus_inc_c;
      endcase
      misaligned_c  = redirect_c && (C_EXT == 0) && target_c[1];
   end

endmodule

// File: rtl/pc_gen_unit.sv
// Registered PC generator: holds the fetch address over bus stalls and buffers one redirect.
module pc_gen_unit
   import pc_gen_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter logic [XLEN-1:0] BOOT_ADDR = '0,
   parameter int unsigned C_EXT     = 0
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            ahb_ready_in,
   input  logic [1:0]      pc_src_in,
   input  logic [XLEN-1:0] epc_in,
   input  logic [XLEN-1:0] trap_address_in,
   input  logic            branch_taken_in,
   input  logic [XLEN-2:0] iaddr_in,
   input  logic            instr_len2_in,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus_inc_out,
   output logic [XLEN-1:0] iaddr_out,
   output logic            fetch_valid_out,
   output logic            misaligned_instr_logic_out,
   output logic            redirect_pending_out
);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] iaddr_q, iaddr_d;
   logic [XLEN-1:0] pend_q, pend_d;
   logic [1:0]      prio_q, prio_d;
   logic            valid_q, valid_d;
   logic            mis_q, mis_d;
   logic            pending_q, pending_d;

   logic [XLEN-1:0] target_c;
   logic            redirect_c;
   logic            misaligned_c;
   logic [1:0]      prio_c;
   logic [XLEN-1:0] apply_addr;
   logic            apply_bad;

   pc_target_sel #(
      .XLEN      (XLEN),
      .BOOT_ADDR (BOOT_ADDR),
      .C_EXT     (C_EXT)
   ) u_target_sel (
      .pc            (pc_q),
      .pc_src        (pc_src_in),
      .epc           (epc_in),
      .trap_address  (trap_address_in),
      .branch_taken  (branch_taken_in),
      .iaddr         (iaddr_in),
      .instr_len2    (instr_len2_in),
      .pc_plus_inc_c (pc_plus_inc_out),
      .target_c      (target_c),
      .redirect_c    (redirect_c),
      .misaligned_c  (misaligned_c),
      .prio_c        (prio_c)
   );

   // next-state and next-register computation
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      iaddr_d    = iaddr_q;
      pend_d     = pend_q;
      prio_d     = prio_q;
      valid_d    = valid_q;
      mis_d      = 1'b0;
      pending_d  = pending_q;
      apply_addr = redirect_c ? target_c : pend_q;
      apply_bad  = redirect_c ? misaligned_c : ((C_EXT == 0) && pend_q[1]);
      case (state_q)
         ST_BOOT: begin
            valid_d = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ahb_ready_in) begin
               if (misaligned_c) begin
                  mis_d = 1'b1;
               end else begin
                  pc_d    = target_c;
                  iaddr_d = target_c;
               end
            end else if (redirect_c) begin
               pend_d    = target_c;
               prio_d    = prio_c;
               pending_d = 1'b1;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ahb_ready_in) begin
               if (apply_bad) begin
                  mis_d = 1'b1;
               end else begin
                  pc_d    = apply_addr;
                  iaddr_d = apply_addr;
               end
               pending_d = 1'b0;
               prio_d    = PRIO_NONE;
               state_d   = ST_RUN;
            end else if (redirect_c &&
                         ((pc_src_in == PC_SRC_TRAP) || (prio_q == PRIO_BRANCH))) begin
               pend_d = target_c;
               prio_d = prio_c;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_BOOT;
         pc_q      <= BOOT_ADDR;
         iaddr_q   <= BOOT_ADDR;
         pend_q    <= BOOT_ADDR;
         prio_q    <= PRIO_NONE;
         valid_q   <= 1'b0;
         mis_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         iaddr_q   <= iaddr_d;
         pend_q    <= pend_d;
         prio_q    <= prio_d;
         valid_q   <= valid_d;
         mis_q     <= mis_d;
         pending_q <= pending_d;
      end
   end

   assign pc_out                     = pc_q;
   assign iaddr_out                  = iaddr_q;
   assign fetch_valid_out            = valid_q;
   assign misaligned_instr_logic_out = mis_q;
   assign redirect_pending_out       = pending_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed table, C-extension sequences and random run vs. a reference model.
module tb_pc_gen_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b0;
   logic [1:0]  src = 2'd3;
   logic [31:0] epc = 32'h40;
   logic [31:0] trap = 32'h80;
   logic        bt = 1'b0;
   logic [31:0] tgt = 32'h0;
   logic        len2 = 1'b0;

   logic [31:0] pc0, plus0, ia0, pc1, plus1, ia1;
   logic        v0, m0, p0, v1, m1, p1;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state, index 0 = C_EXT 0, index 1 = C_EXT 1
   logic [31:0] m_pc [2];
   logic [31:0] m_ia [2];
   logic [31:0] m_paddr [2];
   int          m_pcls [2];
   bit          m_valid [2];
   bit          m_mis [2];
   bit          m_pend [2];
   bit          m_boot [2];

   always #5 clk = ~clk;

   pc_gen_unit #(.XLEN(32), .BOOT_ADDR(32'h0), .C_EXT(0)) u_dut0 (
      .clk_in(clk), .rst_in(rst), .ahb_ready_in(ready), .pc_src_in(src),
      .epc_in(epc), .trap_address_in(trap), .branch_taken_in(bt),
      .iaddr_in(tgt[31:1]), .instr_len2_in(len2),
      .pc_out(pc0), .pc_plus_inc_out(plus0), .iaddr_out(ia0),
      .fetch_valid_out(v0), .misaligned_instr_logic_out(m0),
      .redirect_pending_out(p0));

   pc_gen_unit #(.XLEN(32), .BOOT_ADDR(32'h0), .C_EXT(1)) u_dut1 (
      .clk_in(clk), .rst_in(rst), .ahb_ready_in(ready), .pc_src_in(src),
      .epc_in(epc), .trap_address_in(trap), .branch_taken_in(bt),
      .iaddr_in(tgt[31:1]), .instr_len2_in(len2),
      .pc_out(pc1), .pc_plus_inc_out(plus1), .iaddr_out(ia1),
      .fetch_valid_out(v1), .misaligned_instr_logic_out(m1),
      .redirect_pending_out(p1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // one clock of the architectural rules for a unit with compressed support = (k==1)
   task automatic model_step(input int k);
      logic [31:0] step_v, t, addr;
      int cls;
      bit redir;
      if (rst) begin
         m_boot[k] = 1; m_pc[k] = 0; m_ia[k] = 0; m_valid[k] = 0;
         m_mis[k] = 0; m_pend[k] = 0;
      end else if (m_boot[k]) begin
         m_boot[k] = 0; m_valid[k] = 1; m_mis[k] = 0;
      end else begin
         m_mis[k] = 0;
         step_v = m_pc[k] + ((k == 1 && len2) ? 32'd2 : 32'd4);
         case (src)
            2'd0: begin t = 32'h0; cls = 2; end
            2'd1: begin t = epc;   cls = 2; end
            2'd2: begin t = trap;  cls = 3; end
            default: begin t = bt ? {tgt[31:1], 1'b0} : step_v; cls = 1; end
         endcase
         redir = (src != 2'd3) || bt;
         if (ready) begin
            if (redir || m_pend[k]) begin
               addr = redir ? t : m_paddr[k];
               if (k == 0 && addr[1]) m_mis[k] = 1;
               else begin m_pc[k] = addr; m_ia[k] = addr; end
            end else begin
               m_pc[k] = step_v; m_ia[k] = step_v;
            end
            m_pend[k] = 0;
         end else if (redir) begin
            if (!m_pend[k] || src == 2'd2 || m_pcls[k] == 1) begin
               m_pend[k] = 1; m_paddr[k] = t; m_pcls[k] = cls;
            end
         end
      end
   endtask

   task automatic check_model();
      check("m0_pc",    pc0,   m_pc[0]);
      check("m0_iaddr", ia0,   m_ia[0]);
      check("m0_plus",  plus0, m_pc[0] + 32'd4);
      check("m0_valid", 32'(v0), 32'(m_valid[0]));
      check("m0_mis",   32'(m0), 32'(m_mis[0]));
      check("m0_pend",  32'(p0), 32'(m_pend[0]));
      check("m1_pc",    pc1,   m_pc[1]);
      check("m1_iaddr", ia1,   m_ia[1]);
      check("m1_plus",  plus1, m_pc[1] + (len2 ? 32'd2 : 32'd4));
      check("m1_valid", 32'(v1), 32'(m_valid[1]));
      check("m1_mis",   32'(m1), 32'(m_mis[1]));
      check("m1_pend",  32'(p1), 32'(m_pend[1]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_model();
   endtask

   typedef struct {
      bit          rst;
      bit          ready;
      logic [1:0]  src;
      bit          bt;
      logic [31:0] tgt;
      logic [31:0] e_ia;
      bit          e_valid;
      bit          e_pend;
      bit          e_mis;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit r, input bit rd, input logic [1:0] s, input bit b,
                      input logic [31:0] t, input logic [31:0] ei, input bit ev,
                      input bit ep, input bit em);
      vec_t v;
      v.rst = r; v.ready = rd; v.src = s; v.bt = b; v.tgt = t;
      v.e_ia = ei; v.e_valid = ev; v.e_pend = ep; v.e_mis = em;
      vecs.push_back(v);
   endtask

   initial begin
      // directed sequence, expectations for the C_EXT=0 unit (epc 0x40, trap 0x80)
      add(1, 0, 3, 0, 32'h0,   32'h0,   0, 0, 0);
      add(1, 0, 3, 0, 32'h0,   32'h0,   0, 0, 0);
      add(0, 1, 3, 0, 32'h0,   32'h0,   1, 0, 0);
      add(0, 1, 3, 0, 32'h0,   32'h4,   1, 0, 0);
      add(0, 1, 3, 0, 32'h0,   32'h8,   1, 0, 0);
      add(0, 1, 3, 0, 32'h0,   32'hC,   1, 0, 0);
      add(0, 0, 3, 1, 32'h100, 32'hC,   1, 1, 0);
      add(0, 0, 3, 0, 32'h0,   32'hC,   1, 1, 0);
      add(0, 1, 3, 0, 32'h0,   32'h100, 1, 0, 0);
      add(0, 0, 3, 1, 32'h100, 32'h100, 1, 1, 0);
      add(0, 0, 2, 0, 32'h0,   32'h100, 1, 1, 0);
      add(0, 1, 3, 0, 32'h0,   32'h80,  1, 0, 0);
      add(0, 0, 2, 0, 32'h0,   32'h80,  1, 1, 0);
      add(0, 0, 3, 1, 32'h200, 32'h80,  1, 1, 0);
      add(0, 1, 3, 0, 32'h0,   32'h80,  1, 0, 0);
      add(0, 1, 3, 0, 32'h0,   32'h84,  1, 0, 0);
      add(0, 1, 3, 1, 32'h102, 32'h84,  1, 0, 1);
      add(0, 1, 2, 0, 32'h0,   32'h80,  1, 0, 0);
      add(0, 1, 1, 0, 32'h0,   32'h40,  1, 0, 0);
      add(0, 1, 0, 0, 32'h0,   32'h0,   1, 0, 0);
      add(0, 1, 3, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0);
      add(0, 1, 3, 0, 32'h0,   32'h0,   1, 0, 0);
      add(0, 1, 3, 0, 32'h0,   32'h4,   1, 0, 0);
      add(0, 0, 3, 1, 32'h100, 32'h4,   1, 1, 0);
      add(1, 0, 3, 0, 32'h0,   32'h0,   0, 0, 0);
      add(0, 0, 3, 0, 32'h0,   32'h0,   1, 0, 0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; ready = vecs[i].ready; src = vecs[i].src;
         bt = vecs[i].bt; tgt = vecs[i].tgt;
         cycle();
         check($sformatf("tbl%0d_iaddr", i), ia0, vecs[i].e_ia);
         check($sformatf("tbl%0d_pc", i), pc0, vecs[i].e_ia);
         check($sformatf("tbl%0d_valid", i), 32'(v0), 32'(vecs[i].e_valid));
         check($sformatf("tbl%0d_pend", i), 32'(p0), 32'(vecs[i].e_pend));
         check($sformatf("tbl%0d_mis", i), 32'(m0), 32'(vecs[i].e_mis));
      end

      // compressed stepping: only the C_EXT=1 unit honours instr_len2
      ready = 1; src = 3; bt = 0; len2 = 1;
      for (int i = 1; i <= 3; i++) begin
         cycle();
         check($sformatf("c1_step%0d", i), ia1, 32'(2 * i));
         check($sformatf("c0_step%0d", i), ia0, 32'(4 * i));
      end
      len2 = 0;
      // 0x102 is legal with compressed support, misaligned without
      bt = 1; tgt = 32'h102;
      cycle();
      check("c1_0x102_iaddr", ia1, 32'h102);
      check("c1_0x102_mis", 32'(m1), 32'h0);
      check("c0_0x102_iaddr", ia0, 32'hC);
      check("c0_0x102_mis", 32'(m0), 32'h1);
      bt = 0;
      cycle();
      check("c0_mis_clears", 32'(m0), 32'h0);

      // randomized run against the model
      for (int i = 0; i < 600; i++) begin
         rst   = ($urandom_range(0, 59) == 0);
         ready = ($urandom_range(0, 2) != 0);
         src   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
         bt    = ($urandom_range(0, 3) == 0);
         tgt   = $urandom;
         epc   = $urandom & 32'hFFFF_FFFE;
         trap  = $urandom & 32'hFFFF_FFFC;
         len2  = 1'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
